// File: rtl/vga_fetch_pkg.sv
// Shared constants and types for the VGA display prefetcher.
package vga_fetch_pkg;

    localparam int MEM_W        = 36;      // memory word, two pixels
    localparam int PIX_W        = 18;      // one pixel = half a word
    localparam int DEPTH        = 16;      // FIFO depth in words
    localparam int LOG_DEPTH    = 4;
    localparam int READ_LATENCY = 2;       // done_vga -> vga_pixel valid
    localparam int FRAME_WORDS  = 153600;  // 640*480/2 words per frame
    localparam int LOG_ADDR     = 18;      // word address width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Even pixels live in the low half of a word, odd pixels in the high half.
    function automatic logic [PIX_W-1:0] pick_half(input logic [MEM_W-1:0] w,
                                                   input logic hi);
        return hi ? w[MEM_W-1:PIX_W] : w[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/vga_fetch_sync_fifo.sv
// Single-clock word FIFO with a synchronous clear and occupancy count.
module vga_fetch_sync_fifo
    import vga_fetch_pkg::*;
#(
    parameter int W  = MEM_W,
    parameter int D  = DEPTH,
    parameter int LD = LOG_DEPTH
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [LD:0]   count
);

    logic [W-1:0]  mem_q [D];
    logic [LD-1:0] wr_ptr_q, rd_ptr_q;
    logic [LD:0]   count_q;
    logic          do_wr, do_rd;

    assign empty = (count_q == '0);
    assign full  = (count_q == (LD+1)'(D));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];
    assign do_wr = wr_en && !full && !clear;
    assign do_rd = rd_en && !empty && !clear;

    // Pointer and occupancy tracking; clear empties the FIFO in one cycle.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + LD'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + LD'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (LD+1)'(1);
                2'b01:   count_q <= count_q - (LD+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clock) begin
        if (do_wr) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/vga_fetch.sv
// VGA prefetcher: credit-limited sequential reads, latency tagging, word FIFO
// and two-pixels-per-word unpacking.
module vga_fetch
    import vga_fetch_pkg::*;
#(
    parameter int WORDS_PER_FRAME = FRAME_WORDS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             pixel_req,
    output logic [PIX_W-1:0] pixel_out,
    output logic             pixel_valid,
    output logic             underflow,
    output logic             vga_flag,
    input  logic             done_vga,
    input  logic [MEM_W-1:0] vga_pixel
);

    localparam logic [LOG_DEPTH+1:0] CREDIT_MAX = (LOG_DEPTH+2)'(DEPTH);
    localparam logic [LOG_ADDR-1:0]  LAST_WORD  = LOG_ADDR'(WORDS_PER_FRAME - 1);

    state_t                  state_q;
    logic [LOG_ADDR-1:0]     words_req_q;
    logic [LOG_DEPTH:0]      in_flight_q;
    logic [READ_LATENCY-1:0] lat_q;
    logic                    half_q;
    logic [PIX_W-1:0]        pixel_out_q;
    logic                    pixel_valid_q, underflow_q;

    logic [MEM_W-1:0]        fifo_dout;
    logic                    fifo_empty, fifo_full;
    logic [LOG_DEPTH:0]      fifo_count;
    logic [LOG_DEPTH+1:0]    credit;
    logic                    accept, ret, push, pop;

    // Words already buffered plus words still on their way back: requesting
    // only while this stays below DEPTH means every return has a slot.
    assign credit   = {1'b0, fifo_count} + {1'b0, in_flight_q};
    assign vga_flag = (state_q == ST_FETCH) && !frame_start && (credit < CREDIT_MAX);
    assign accept   = vga_flag && done_vga;
    assign ret      = lat_q[READ_LATENCY-1];
    assign push     = ret && !frame_start && !fifo_full;
    assign pop      = pixel_req && !fifo_empty && half_q && !frame_start;

    vga_fetch_sync_fifo #(.W(MEM_W), .D(DEPTH), .LD(LOG_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (frame_start),
        .wr_en (push),
        .rd_en (pop),
        .din   (vga_pixel),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Frame FSM, request counter, in-flight credit and return-tag pipeline.
    // Clearing the tag pipeline on frame_start discards stale returns.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            words_req_q <= '0;
            in_flight_q <= '0;
            lat_q       <= '0;
        end else if (frame_start) begin
            state_q     <= ST_FETCH;
            words_req_q <= '0;
            in_flight_q <= '0;
            lat_q       <= '0;
        end else begin
            lat_q <= {lat_q[READ_LATENCY-2:0], accept};
            case ({accept, ret})
                2'b10:   in_flight_q <= in_flight_q + (LOG_DEPTH+1)'(1);
                2'b01:   in_flight_q <= in_flight_q - (LOG_DEPTH+1)'(1);
                default: in_flight_q <= in_flight_q;
            endcase
            if (accept) begin
                words_req_q <= words_req_q + LOG_ADDR'(1);
                if (state_q == ST_FETCH && words_req_q == LAST_WORD)
                    state_q <= ST_DRAIN;
            end
        end
    end

    // Pixel unpacker: low half first, then high half, popping after the high.
    always_ff @(posedge clock) begin
        if (reset) begin
            half_q        <= 1'b0;
            pixel_out_q   <= '0;
            pixel_valid_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else if (frame_start) begin
            half_q        <= 1'b0;
            pixel_valid_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else if (pixel_req) begin
            pixel_valid_q <= 1'b1;
            if (!fifo_empty) begin
                pixel_out_q <= pick_half(fifo_dout, half_q);
                half_q      <= ~half_q;
            end else begin
                pixel_out_q <= '0;
                underflow_q <= 1'b1;
            end
        end else begin
            pixel_valid_q <= 1'b0;
        end
    end

    assign pixel_out   = pixel_out_q;
    assign pixel_valid = pixel_valid_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_fetch.sv
// Self-checking bench for vga_fetch with a queue-based reference model.
// The frame length is shortened to 24 words so a full frame fits in a run
// while still exceeding the 16-word buffer.
module tb_vga_fetch;
    import vga_fetch_pkg::*;

    localparam int WPF = 24;

    logic             clock = 1'b0;
    logic             reset, frame_start, pixel_req, done_vga;
    logic [MEM_W-1:0] vga_pixel;
    logic [PIX_W-1:0] pixel_out;
    logic             pixel_valid, underflow, vga_flag;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [PIX_W-1:0] pq[$];          // pixels available in the buffer, in order
    bit               m_fetch, m_uf, m_valid;
    int               m_acc;
    logic [PIX_W-1:0] m_out;
    bit               s1_v, s2_v;     // live reads returning next cycle / this cycle
    logic [MEM_W-1:0] s1_d, s2_d;     // memory return pipeline (drives vga_pixel)
    logic [MEM_W-1:0] words [0:31];   // memory contents for the current frame

    always #5 clock = ~clock;

    vga_fetch #(.WORDS_PER_FRAME(WPF)) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .pixel_req   (pixel_req),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .underflow   (underflow),
        .vga_flag    (vga_flag),
        .done_vga    (done_vga),
        .vga_pixel   (vga_pixel)
    );

    task automatic fill_words();
        logic [31:0] r1, r2;
        for (int i = 0; i < 32; i++) begin
            r1 = $urandom; r2 = $urandom;
            words[i] = {r1[3:0], r2};
        end
    endtask

    // One clock cycle: check vga_flag against the credit rule, advance the
    // model, clock the DUT and check the registered outputs.
    task automatic tick();
        bit exp_flag, acc;
        int inflight, fwords, idx;
        logic [31:0] r1, r2;
        #1;
        inflight = int'(s1_v) + int'(s2_v);
        fwords   = (pq.size() + 1) / 2;
        exp_flag = m_fetch && !frame_start && (fwords + inflight < DEPTH);
        checks++;
        if (vga_flag !== exp_flag) begin
            failures++;
            $display("FAIL vga_flag t=%0t got=%b exp=%b", $time, vga_flag, exp_flag);
        end
        acc = exp_flag && done_vga;
        idx = m_acc;
        if (reset) begin
            pq.delete(); m_fetch = 0; m_uf = 0; m_acc = 0;
            m_out = '0; m_valid = 0; s1_v = 0; s2_v = 0; acc = 0;
        end else if (frame_start) begin
            pq.delete(); m_fetch = 1; m_uf = 0; m_acc = 0;
            m_valid = 0; s1_v = 0; s2_v = 0;
        end else begin
            if (pixel_req) begin
                m_valid = 1;
                if (pq.size() > 0) m_out = pq.pop_front();
                else begin m_out = '0; m_uf = 1; end
            end else m_valid = 0;
            if (s2_v) begin
                pq.push_back(s2_d[PIX_W-1:0]);
                pq.push_back(s2_d[MEM_W-1:PIX_W]);
            end
            if (acc) begin
                m_acc++;
                if (m_acc == WPF) m_fetch = 0;
            end
        end
        @(posedge clock); #1;
        checks++;
        if (pixel_valid !== m_valid) begin
            failures++;
            $display("FAIL pixel_valid t=%0t got=%b exp=%b", $time, pixel_valid, m_valid);
        end
        checks++;
        if (pixel_out !== m_out) begin
            failures++;
            $display("FAIL pixel_out t=%0t got=%h exp=%h", $time, pixel_out, m_out);
        end
        checks++;
        if (underflow !== m_uf) begin
            failures++;
            $display("FAIL underflow t=%0t got=%b exp=%b", $time, underflow, m_uf);
        end
        s2_v = s1_v; s2_d = s1_d;
        s1_v = acc;
        r1 = $urandom; r2 = $urandom;
        s1_d = acc ? words[idx] : {r1[3:0], r2};
        vga_pixel = s2_d;
    endtask

    task automatic test_reset();
        reset = 1; frame_start = 0; pixel_req = 0; done_vga = 0;
        tick(); tick();
        checks++;
        if (pixel_out !== '0 || pixel_valid !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%b/%b exp=0/0/0", pixel_out, pixel_valid, underflow);
        end
        reset = 0; done_vga = 1;
        repeat (3) tick();
        checks++;
        if (vga_flag !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_flag got=%b exp=0", vga_flag);
        end
        done_vga = 0;
    endtask

    task automatic test_fill();
        int n;
        fill_words();
        frame_start = 1; tick(); frame_start = 0; done_vga = 1;
        #1;
        checks++;
        if (vga_flag !== 1'b1) begin
            failures++;
            $display("FAIL first_flag got=%b exp=1", vga_flag);
        end
        n = 0;
        repeat (30) begin
            #1; if (vga_flag && done_vga) n++;
            tick();
        end
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("FAIL fill_accepts got=%0d exp=%0d", n, DEPTH);
        end
        done_vga = 0; pixel_req = 1;
        repeat (2*DEPTH) tick();
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL fill_no_early_underflow got=%b exp=0", underflow);
        end
        tick();
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL fill_drained_underflow got=%b exp=1", underflow);
        end
        pixel_req = 0;
    endtask

    task automatic test_unpack();
        logic [PIX_W-1:0] exp_px [4];
        exp_px[0] = 18'h00002; exp_px[1] = 18'h00001;
        exp_px[2] = 18'h00004; exp_px[3] = 18'h00003;
        fill_words();
        words[0] = {18'h00001, 18'h00002};
        words[1] = {18'h00003, 18'h00004};
        frame_start = 1; tick(); frame_start = 0;
        done_vga = 1; tick(); tick();
        done_vga = 0; repeat (3) tick();
        pixel_req = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (pixel_out !== exp_px[i] || pixel_valid !== 1'b1) begin
                failures++;
                $display("FAIL unpack_px%0d got=%h/%b exp=%h/1", i, pixel_out, pixel_valid, exp_px[i]);
            end
        end
        pixel_req = 0;
    endtask

    task automatic test_underflow();
        fill_words();
        frame_start = 1; tick(); frame_start = 0;
        done_vga = 1; repeat (6) tick();
        done_vga = 0; pixel_req = 1;
        repeat (40) tick();
        checks++;
        if (underflow !== 1'b1 || pixel_out !== '0 || pixel_valid !== 1'b1) begin
            failures++;
            $display("FAIL underflow_set got=%b/%h/%b exp=1/0/1", underflow, pixel_out, pixel_valid);
        end
        pixel_req = 0; repeat (3) tick();
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL underflow_sticky got=%b exp=1", underflow);
        end
        frame_start = 1; tick(); frame_start = 0;
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clear got=%b exp=0", underflow);
        end
    endtask

    task automatic test_restart();
        logic [PIX_W-1:0] first;
        fill_words();
        frame_start = 1; tick(); frame_start = 0;
        done_vga = 1; repeat (8) tick();
        fill_words();
        first = words[0][PIX_W-1:0];
        frame_start = 1; tick(); frame_start = 0;
        tick(); done_vga = 0;
        repeat (3) tick();
        pixel_req = 1; tick(); pixel_req = 0;
        checks++;
        if (pixel_out !== first) begin
            failures++;
            $display("FAIL restart_first_pixel got=%h exp=%h", pixel_out, first);
        end
        repeat (3) tick();
    endtask

    task automatic test_frame_end();
        int n_acc, n_req, first_uf, cyc;
        fill_words();
        frame_start = 1; tick(); frame_start = 0;
        n_acc = 0; n_req = 0; first_uf = 0; cyc = 0;
        while (first_uf == 0 && cyc < 600) begin
            done_vga  = ($urandom_range(0, 3) != 0);
            pixel_req = (cyc >= 40) && ($urandom_range(0, 2) == 0);
            #1;
            if (vga_flag && done_vga) n_acc++;
            if (pixel_req) n_req++;
            tick();
            if (underflow === 1'b1) first_uf = n_req;
            cyc++;
        end
        pixel_req = 0;
        checks++;
        if (n_acc != WPF) begin
            failures++;
            $display("FAIL frame_accepts got=%0d exp=%0d", n_acc, WPF);
        end
        checks++;
        if (first_uf != 2*WPF + 1) begin
            failures++;
            $display("FAIL frame_underflow_req got=%0d exp=%0d", first_uf, 2*WPF + 1);
        end
        done_vga = 1;
        repeat (10) tick();
        checks++;
        if (vga_flag !== 1'b0) begin
            failures++;
            $display("FAIL drain_no_flag got=%b exp=0", vga_flag);
        end
        done_vga = 0;
    endtask

    task automatic test_reset_mid();
        fill_words();
        frame_start = 1; tick(); frame_start = 0;
        done_vga = 1; repeat (6) tick();
        pixel_req = 1; repeat (2) tick();
        reset = 1; pixel_req = 0; tick(); reset = 0;
        checks++;
        if (pixel_out !== '0 || pixel_valid !== 1'b0 || underflow !== 1'b0 || vga_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got=%h/%b/%b/%b exp=0/0/0/0", pixel_out, pixel_valid, underflow, vga_flag);
        end
        repeat (5) tick();
        checks++;
        if (vga_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle got=%b exp=0", vga_flag);
        end
        done_vga = 0;
    endtask

    task automatic test_random();
        fill_words();
        frame_start = 1; tick(); frame_start = 0;
        for (int i = 0; i < 400; i++) begin
            done_vga    = $urandom_range(0, 1);
            frame_start = ($urandom_range(0, 99) == 0);
            pixel_req   = !frame_start && ($urandom_range(0, 1) == 1);
            if (frame_start) fill_words();
            tick();
        end
        frame_start = 0; pixel_req = 0; done_vga = 0;
    endtask

    initial begin
        reset = 1; frame_start = 0; pixel_req = 0; done_vga = 0;
        vga_pixel = '0;
        s1_v = 0; s2_v = 0; s1_d = '0; s2_d = '0;
        m_fetch = 0; m_uf = 0; m_valid = 0; m_acc = 0; m_out = '0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_fill();
        test_unpack();
        test_underflow();
        test_restart();
        test_frame_end();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
